serial_transceiver: RTL and testbench

SERIAL_TRANSCEIVER -- requirements
Module: serial_transceiver

---
 rtl/serial_transceiver.sv | 137 +++++++++++++
 tb/tb_serial_transceiver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_transceiver.sv
// MSB-first serializer: a shadow word is captured, then shifted out with each bit held BIT_CYCLES clocks.
// Optional even-parity bit after the LSB when SERIAL_PARITY_EN is defined.
module serial_transceiver #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic                  SampleData,
    input  logic                  TxData,
    output logic                  Dout,
    output logic                  DoutValid,
    output logic                  TxBusy,
    output logic                  TxDone
);

`ifdef SERIAL_PARITY_EN
    localparam int NUM_BITS = DATA_WIDTH + 1;
`else
    localparam int NUM_BITS = DATA_WIDTH;
`endif
    localparam int BW = $clog2(NUM_BITS + 1);
    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOADED = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] shadow_reg, shadow_next;
    logic [BW-1:0]         bit_cnt_reg, bit_cnt_next;
    logic [CW-1:0]         cyc_cnt_reg, cyc_cnt_next;
    logic [DATA_WIDTH-1:0] bit_hit;
    logic                  data_bit;
    logic                  tx_bit;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= IDLE;
            shadow_reg  <= '0;
            bit_cnt_reg <= '0;
            cyc_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            shadow_reg  <= shadow_next;
            bit_cnt_reg <= bit_cnt_next;
            cyc_cnt_reg <= cyc_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shadow_next  = shadow_reg;
        bit_cnt_next = bit_cnt_reg;
        cyc_cnt_next = cyc_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (SampleData) begin
                    shadow_next = DataIn;
                    state_next  = LOADED;
                end
            end
            LOADED: begin
                // A capture request outranks a simultaneous transmit request.
                if (SampleData) begin
                    shadow_next = DataIn;
                end else if (TxData) begin
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                    cyc_cnt_next = '0;
                end
            end
            SHIFT: begin
                if (cyc_cnt_reg == CYC_LAST) begin
                    cyc_cnt_next = '0;
                    if (bit_cnt_reg == LAST_BIT) begin
                        state_next = DONE;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + BW'(1);
                    end
                end else begin
                    cyc_cnt_next = cyc_cnt_reg + CW'(1);
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-hot select of shadow[DATA_WIDTH-1-bit_cnt] without a variable index.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit_sel
            assign bit_hit[gi] = (bit_cnt_reg == BW'(gi)) & shadow_reg[DATA_WIDTH-1-gi];
        end
    endgenerate

    assign data_bit = |bit_hit;

`ifdef SERIAL_PARITY_EN
    assign tx_bit = (bit_cnt_reg == BW'(DATA_WIDTH)) ? ^shadow_reg : data_bit;
`else
    assign tx_bit = data_bit;
`endif

    always_comb begin
        Dout      = 1'b0;
        DoutValid = 1'b0;
        TxBusy    = 1'b0;
        TxDone    = 1'b0;
        case (state_reg)
            SHIFT: begin
                Dout      = tx_bit;
                DoutValid = 1'b1;
                TxBusy    = 1'b1;
            end
            DONE: begin
                TxBusy = 1'b1;
                TxDone = 1'b1;
            end
            default: begin
                Dout = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_transceiver.sv
// Bench for serial_transceiver: two instances (BIT_CYCLES 1 and 3) share stimulus and are checked
// every cycle against a frame-position reference model, plus directed vectors and corner sequences.
module tb_serial_transceiver;
    localparam int DW = 8;
`ifdef SERIAL_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB = DW + PAR;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic          rst, sd, tx;
    logic [DW-1:0] din;
    logic d1_dout, d1_valid, d1_busy, d1_done;
    logic d3_dout, d3_valid, d3_busy, d3_done;

    serial_transceiver #(.DATA_WIDTH(DW), .BIT_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(rst), .DataIn(din), .SampleData(sd), .TxData(tx),
        .Dout(d1_dout), .DoutValid(d1_valid), .TxBusy(d1_busy), .TxDone(d1_done)
    );

    serial_transceiver #(.DATA_WIDTH(DW), .BIT_CYCLES(3)) dut3 (
        .Clk(Clk), .Reset(rst), .DataIn(din), .SampleData(sd), .TxData(tx),
        .Dout(d3_dout), .DoutValid(d3_valid), .TxBusy(d3_busy), .TxDone(d3_done)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a frame is a position counter; outputs follow from the position by arithmetic.
    int            bc_m[2];
    logic          active_m[2];
    logic          loaded_m[2];
    int            pos_m[2];
    logic [DW-1:0] word_m[2];

    function automatic logic [3:0] model_out(input int m);
        int b;
        b = 0;
        if (!active_m[m]) return 4'b0000;
        if (pos_m[m] < NB * bc_m[m]) begin
            b = pos_m[m] / bc_m[m];
            if (b < DW) return {word_m[m][DW-1-b], 3'b110};
            return {^word_m[m], 3'b110};
        end
        return 4'b0011;
    endfunction

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got={dout,valid,busy,done}=%b expected=%b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic t, input logic [DW-1:0] d);
        rst = r; sd = s; tx = t; din = d;
        @(posedge Clk);
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                active_m[m] = 1'b0; loaded_m[m] = 1'b0; pos_m[m] = 0; word_m[m] = '0;
            end else if (active_m[m]) begin
                pos_m[m]++;
                if (pos_m[m] > NB * bc_m[m]) begin
                    active_m[m] = 1'b0; loaded_m[m] = 1'b0;
                end
            end else if (s) begin
                word_m[m] = d; loaded_m[m] = 1'b1;
            end else if (t && loaded_m[m]) begin
                active_m[m] = 1'b1; pos_m[m] = 0;
            end
        end
        #1;
        chk("model_bc1", {d1_dout, d1_valid, d1_busy, d1_done}, model_out(0));
        chk("model_bc3", {d3_dout, d3_valid, d3_busy, d3_done}, model_out(1));
    endtask

    typedef struct {
        logic          rst, sd, tx;
        logic [DW-1:0] din;
        logic [3:0]    exp;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic s, input logic t, input logic [DW-1:0] d,
                           input logic [3:0] e);
        vec_t v;
        v.rst = r; v.sd = s; v.tx = t; v.din = d; v.exp = e;
        vecs.push_back(v);
    endtask

    // Rows for a whole BIT_CYCLES=1 frame of w; the first row carries the TxData request.
    task automatic add_frame(input logic [DW-1:0] w, input logic [DW-1:0] d_shift, input logic t_shift);
        add_vec(1'b0, 1'b0, 1'b1, d_shift, {w[DW-1], 3'b110});
        for (int i = DW - 2; i >= 0; i--) add_vec(1'b0, 1'b0, t_shift, d_shift, {w[i], 3'b110});
        if (PAR == 1) add_vec(1'b0, 1'b0, t_shift, d_shift, {^w, 3'b110});
        add_vec(1'b0, 1'b0, t_shift, d_shift, 4'b0011);
    endtask

    int cnt_a, cnt_b, done_at;

    initial begin
        bc_m[0] = 1; bc_m[1] = 3;
        for (int m = 0; m < 2; m++) begin
            active_m[m] = 1'b0; loaded_m[m] = 1'b0; pos_m[m] = 0; word_m[m] = '0;
        end
        rst = 1'b1; sd = 1'b0; tx = 1'b0; din = '0;

        // Directed vectors (expectations for the BIT_CYCLES=1 instance)
        add_vec(1'b1, 1'b0, 1'b0, 8'h00, 4'b0000);
        add_vec(1'b0, 1'b0, 1'b1, 8'h00, 4'b0000);
        add_vec(1'b0, 1'b1, 1'b0, 8'hA5, 4'b0000);
        add_frame(8'hA5, 8'h00, 1'b0);
        add_vec(1'b0, 1'b0, 1'b0, 8'h00, 4'b0000);
        add_vec(1'b0, 1'b1, 1'b1, 8'h3C, 4'b0000);
        add_frame(8'h3C, 8'hFF, 1'b1);
        add_vec(1'b0, 1'b0, 1'b1, 8'hFF, 4'b0000);
        add_vec(1'b0, 1'b0, 1'b1, 8'hFF, 4'b0000);
        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].sd, vecs[i].tx, vecs[i].din);
            chk($sformatf("vec%0d", i), {d1_dout, d1_valid, d1_busy, d1_done}, vecs[i].exp);
            $display("vec %0d rst=%b sd=%b tx=%b din=%h out=%b", i, vecs[i].rst, vecs[i].sd, vecs[i].tx,
                     vecs[i].din, {d1_dout, d1_valid, d1_busy, d1_done});
        end

        // 8'h81 on the BIT_CYCLES=3 instance: count Dout highs and locate TxDone
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h81);
        cnt_a = 0; done_at = -1;
        for (int c = 1; c <= 3 * NB + 4; c++) begin
            step(1'b0, 1'b0, (c == 1), 8'h00);
            if (d3_dout && d3_valid) cnt_a++;
            if (d3_done) done_at = c;
        end
        chk_int("bc3_ones", cnt_a, 6);
        chk_int("bc3_done_cycle", done_at, 3 * NB + 1);
        $display("frame 81 bc3 ones=%0d done_cycle=%0d", cnt_a, done_at);

        // Parity-sensitive word 8'h07
        step(1'b0, 1'b1, 1'b0, 8'h07);
        for (int c = 0; c < 3 * NB + 3; c++) step(1'b0, 1'b0, (c == 0), 8'h00);

        // Reset after the 4th bit of 8'hA5, then TxData held: nothing further
        step(1'b0, 1'b1, 1'b0, 8'hA5);
        for (int c = 0; c < 4; c++) step(1'b0, 1'b0, (c == 0), 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        chk("abort_bc1", {d1_dout, d1_valid, d1_busy, d1_done}, 4'b0000);
        chk("abort_bc3", {d3_dout, d3_valid, d3_busy, d3_done}, 4'b0000);
        cnt_a = 0;
        for (int c = 0; c < 20; c++) begin
            step(1'b0, 1'b0, 1'b1, 8'(c));
            if (d1_valid || d1_done || d3_valid || d3_done) cnt_a++;
        end
        chk_int("after_abort_activity", cnt_a, 0);

        // Inputs ignored while reset is held
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 1'b1, 8'hFF);
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 1'b1, 8'h00);

        // TxData held through DONE into IDLE: one pulse only
        step(1'b0, 1'b1, 1'b0, 8'h5A);
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < NB + 21; c++) begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            if (d1_done) cnt_a++;
            if (c > NB && d1_valid) cnt_b++;
        end
        chk_int("held_tx_done_pulses", cnt_a, 1);
        chk_int("held_tx_extra_valid", cnt_b, 0);

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
